core_sequencer: RTL
===================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of PC, instruction and counter paths.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 Parameter TIMEOUT, default 16: maximum cycles to wait for a memory ack.
REQ-004 Clocking SHALL be one clock, clk; reset SHALL be rst, synchronous and active-high.
REQ-005 Ports (name  direction  width  meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- run  in  1  level; permits instruction issue.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  DATA_WIDTH  fetch address, always equal to pc.
- imem_ack  in  1  fetch data valid.
- imem_rdata  in  32  fetched instruction.
- ir  out  32  instruction register; drives ALU opcode/func/imm decode.
- pc  out  DATA_WIDTH  current PC; drives ALU pc_current_address.
- alu_pc_next  in  DATA_WIDTH  next PC from ALU.
- alu_rf_we  in  1  ALU write-enable request.
- alu_ram_we  in  1  ALU store request.
- dmem_req  out  1  data memory access request.
- dmem_ack  in  1  data access complete.
- ram_we  out  1  gated RAM write enable.
- rf_we  out  1  gated register-file write strobe.
- state  out  3  FSM state encoding.
- halted  out  1  high in HALT.
- cause  out  3  halt cause.
- instret  out  DATA_WIDTH  retired-instruction count.

Function
REQ-006 State encodings SHALL be IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6.
REQ-007 IDLE: run=1 -> FETCH next cycle; otherwise remain in IDLE.
REQ-008 FETCH: imem_req=1.
- imem_ack=1 (same-cycle ack allowed) -> ir<=imem_rdata, go to DECODE.
REQ-009 DECODE: one cycle; ir[6:0] decides the next state:
- ir[6:0] in {0110011, 0010011, 1100011, 0000011, 0100011, 0110111, 0010111, 1101111, 1100111} -> EXECUTE.
- ir[6:0] = 1110011 -> HALT, cause=2 (ECALL).
- any other value -> HALT, cause=1 (illegal).
REQ-010 EXECUTE: one cycle.
- opcode 0000011 or 0100011 -> MEM.
- any other opcode -> WRITEBACK.
REQ-011 MEM: dmem_req=1; ram_we = alu_ram_we AND (opcode==0100011).
- dmem_ack=1 -> WRITEBACK.
REQ-012 Wait counter SHALL clear on entry to FETCH and MEM and increment each cycle without ack.
- reaching TIMEOUT without ack -> HALT, cause=3.
- an ack arriving in the same cycle the counter reaches TIMEOUT wins.
REQ-013 WRITEBACK: one cycle.
- rf_we = alu_rf_we for opcodes other than 1100011 and 0100011; rf_we=0 for those two.
- pc<=alu_pc_next; instret<=instret+1, wrapping modulo 2^DATA_WIDTH.
- run=1 -> FETCH; run=0 -> IDLE.
REQ-014 In WRITEBACK with alu_pc_next[1:0]!=0: pc unchanged, rf_we=0, instret unchanged, go to HALT, cause=4 (misaligned).
REQ-015 rf_we, ram_we, imem_req and dmem_req SHALL be 0 in every state other than those listed above.
REQ-016 rf_we SHALL be high at most one cycle per instruction.
REQ-017 ir SHALL change only on a FETCH ack; pc SHALL change only in WRITEBACK.
REQ-018 HALT SHALL be absorbing until rst: halted=1, cause held, all strobes 0.
REQ-019 run deasserted mid-instruction SHALL NOT abort it; the instruction completes and the FSM stops in IDLE.
REQ-020 cause SHALL be 0 in every state except HALT.

Reset
REQ-021 rst=1 at any clock edge, including mid-FETCH/MEM, SHALL set: state=IDLE, pc=RESET_PC, ir=0, instret=0, cause=0, halted=0, wait counter=0.
REQ-022 During reset all request and write strobes SHALL be 0; rst SHALL override every other input.

Verification
REQ-023 ADD flow: rst, then run=1, imem_ack immediate with instruction 0x002081B3, alu_rf_we=1, alu_pc_next=4 -> states 1,2,3,5; exactly one rf_we pulse; pc=4; instret=1.
REQ-024 Store flow: instruction 0x0020A023, dmem_ack delayed 3 cycles -> ram_we high exactly 4 cycles in MEM; rf_we=0 throughout.
REQ-025 Illegal opcode: instruction 0xFFFFFFFF -> HALT, cause=1, halted=1; HALT persists with run=1 until rst.
REQ-026 Timeout: load instruction, dmem_ack held 0 -> HALT after TIMEOUT=16 MEM cycles, cause=3.
REQ-027 Misaligned target: JAL with alu_pc_next=0x6 -> HALT, cause=4; pc unchanged; instret unchanged.
REQ-028 Reset mid-MEM: rst pulse while in MEM -> next cycle state=0, pc=RESET_PC, dmem_req=0, instret=0.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/mem/writeback control
// around an external ALU, with memory-ack timeouts and a sticky halt state.
module core_sequencer #(
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned RESET_PC   = 0,
    parameter int          TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    output logic [31:0]           ir,
    output logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] alu_pc_next,
    input  logic                  alu_rf_we,
    input  logic                  alu_ram_we,
    output logic                  dmem_req,
    input  logic                  dmem_ack,
    output logic                  ram_we,
    output logic                  rf_we,
    output logic [2:0]            state,
    output logic                  halted,
    output logic [2:0]            cause,
    output logic [DATA_WIDTH-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] CAUSE_NONE     = 3'd0;
    localparam logic [2:0] CAUSE_ILLEGAL  = 3'd1;
    localparam logic [2:0] CAUSE_ECALL    = 3'd2;
    localparam logic [2:0] CAUSE_TIMEOUT  = 3'd3;
    localparam logic [2:0] CAUSE_MISALIGN = 3'd4;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           ir_q, ir_d;
    logic [DATA_WIDTH-1:0] instret_q, instret_d;
    logic [2:0]            cause_q, cause_d;
    logic                  halted_q, halted_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;

    logic [6:0] opcode;
    logic       target_aligned;
    logic       op_executable;

    assign opcode         = ir_q[6:0];
    assign target_aligned = (alu_pc_next[1:0] == 2'b00);

    always_comb begin
        case (opcode)
            OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_LOAD, OP_STORE,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: op_executable = 1'b1;
            default:                           op_executable = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        cause_d   = cause_q;
        wait_d    = wait_q;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (op_executable) begin
                    state_d = S_EXECUTE;
                end else if (opcode == OP_SYSTEM) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_ECALL;
                end else begin
                    state_d = S_HALT;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EXECUTE: begin
                if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = S_WRITEBACK;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WRITEBACK: begin
                // A misaligned target retires nothing: pc and instret stay put.
                if (!target_aligned) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_MISALIGN;
                end else begin
                    pc_d      = alu_pc_next;
                    instret_d = instret_q + 1'b1;
                    state_d   = run ? S_FETCH : S_IDLE;
                    wait_d    = '0;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
                cause_d = CAUSE_NONE;
            end
        endcase

        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= DATA_WIDTH'(RESET_PC);
            ir_q      <= '0;
            instret_q <= '0;
            cause_q   <= CAUSE_NONE;
            halted_q  <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
            cause_q   <= cause_d;
            halted_q  <= halted_d;
            wait_q    <= wait_d;
        end
    end

    // Strobes decode the registered state; rst forces them low in the same cycle.
    assign imem_req = !rst && (state_q == S_FETCH);
    assign dmem_req = !rst && (state_q == S_MEM);
    assign ram_we   = !rst && (state_q == S_MEM) && alu_ram_we && (opcode == OP_STORE);
    assign rf_we    = !rst && (state_q == S_WRITEBACK) && target_aligned && alu_rf_we
                      && (opcode != OP_BRANCH) && (opcode != OP_STORE);

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign instret   = instret_q;
    assign state     = state_q;
    assign cause     = cause_q;
    assign halted    = halted_q;

endmodule
